// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and
// scoreboard slot layout.
package cpu_ctrl_pkg;

   localparam int REG_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      LOAD     = 3'd1,
      FLUSH    = 3'd2,
      WAIT_IN  = 3'd3,
      WAIT_OUT = 3'd4
   } ctrl_state_t;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
   } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker (EX, MEM, WB-input) and RAW match logic
// for the decode-stage source operands.
module hazard_scoreboard
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_TRACK = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      advance_i,
   input  logic                      flush_i,
   input  logic                      id_valid_i,
   input  logic                      id_enable_i,
   input  logic                      id_reg_write_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
   input  logic                      id_uses_rs_i,
   input  logic                      id_uses_rt_i,
   output logic                      hazard_o
);

   sb_slot_t slot_q [NUM_TRACK];
   logic     alloc;
   logic     rs_hit;
   logic     rt_hit;

   assign alloc = id_valid_i && id_enable_i && id_reg_write_i
                  && (id_rd_i != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         for (int k = 0; k < NUM_TRACK; k++) begin
            slot_q[k] <= '0;
         end
      end else if (advance_i) begin
         slot_q[0] <= '{valid: alloc, rd: id_rd_i};
         for (int k = 1; k < NUM_TRACK; k++) begin
            slot_q[k] <= slot_q[k-1];
         end
      end
   end

   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int k = 0; k < NUM_TRACK; k++) begin
         if (slot_q[k].valid && slot_q[k].rd == id_rs_i) rs_hit = 1'b1;
         if (slot_q[k].valid && slot_q[k].rd == id_rt_i) rt_hit = 1'b1;
      end
   end

   // r0 is hardwired, so it can never carry a dependence
   assign hazard_o = id_valid_i
                     && ((id_uses_rs_i && id_rs_i != '0 && rs_hit)
                      || (id_uses_rt_i && id_rt_i != '0 && rt_hit));

endmodule

// File: rtl/pipeline_controller.sv
// Six-stage pipeline sequencer: enables, bubbles, flushes, UART/load freeze.
// Optional hazard/redirect counters are built when STALL_COUNTERS_EN is defined.
module pipeline_controller #(
   parameter int NUM_TRACK      = 3,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      load_start,
   input  logic                      load_end,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic                      id_uses_rs,
   input  logic                      id_uses_rt,
   input  logic                      id_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      wb_redirect,
   input  logic                      wb_uart_read,
   input  logic                      input_ready,
   input  logic                      ex_uart_write,
   input  logic                      sender_full,
   output logic                      pc_enable,
   output logic                      id_enable,
   output logic                      op_bubble,
   output logic                      pipe_enable,
   output logic                      flush,
   output logic                      loading,
   output logic [2:0]                state,
   output logic [31:0]               stall_cycles,
   output logic [31:0]               flush_count
);

   import cpu_ctrl_pkg::*;

   ctrl_state_t state_q;
   ctrl_state_t state_d;
   logic        hazard;
   logic        run_eval;

   hazard_scoreboard #(
      .NUM_TRACK(NUM_TRACK)
   ) u_sb (
      .clk_i         (CLK),
      .rst_i         (reset),
      .advance_i     (pipe_enable),
      .flush_i       (flush),
      .id_valid_i    (id_valid),
      .id_enable_i   (id_enable),
      .id_reg_write_i(id_reg_write),
      .id_rd_i       (id_rd),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_uses_rs_i  (id_uses_rs),
      .id_uses_rt_i  (id_uses_rt),
      .hazard_o      (hazard)
   );

   always_ff @(posedge CLK) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      pc_enable   = 1'b1;
      id_enable   = 1'b1;
      pipe_enable = 1'b1;
      op_bubble   = 1'b0;
      flush       = 1'b0;
      loading     = 1'b0;
      run_eval    = 1'b0;
      unique case (state_q)
         RUN:      run_eval = 1'b1;
         LOAD: begin
            loading     = 1'b1;
            pipe_enable = 1'b0;
            flush       = 1'b1;
            pc_enable   = 1'b0;
            id_enable   = 1'b0;
            if (load_end) state_d = FLUSH;
         end
         FLUSH: begin
            flush     = 1'b1;
            id_enable = 1'b0;
            state_d   = RUN;
         end
         WAIT_IN:  run_eval = input_ready;
         WAIT_OUT: run_eval = !sender_full;
         default:  state_d = RUN;
      endcase
      if (!run_eval && (state_q == WAIT_IN || state_q == WAIT_OUT)) begin
         pc_enable   = 1'b0;
         id_enable   = 1'b0;
         pipe_enable = 1'b0;
      end
      // a cleared wait resolves with RUN rules in the same cycle
      if (run_eval) begin
         state_d = RUN;
         if (load_start && state_q == RUN) begin
            state_d     = LOAD;
            flush       = 1'b1;
            pc_enable   = 1'b0;
            id_enable   = 1'b0;
            pipe_enable = 1'b0;
         end else if (wb_redirect) begin
            state_d = FLUSH;
            flush   = 1'b1;
         end else if (wb_uart_read && !input_ready) begin
            state_d     = WAIT_IN;
            pc_enable   = 1'b0;
            id_enable   = 1'b0;
            pipe_enable = 1'b0;
         end else if (ex_uart_write && sender_full) begin
            state_d     = WAIT_OUT;
            pc_enable   = 1'b0;
            id_enable   = 1'b0;
            pipe_enable = 1'b0;
         end else if (hazard) begin
            pc_enable = 1'b0;
            id_enable = 1'b0;
            op_bubble = 1'b1;
         end
      end
   end

   assign state = state_q;

`ifdef STALL_COUNTERS_EN
   logic [31:0] stall_q;
   logic [31:0] redir_q;
   logic        redir_evt;

   // FLUSH entered from anywhere but LOAD means a redirect was taken
   assign redir_evt = (state_d == FLUSH) && (state_q != LOAD);

   always_ff @(posedge CLK) begin
      if (reset) begin
         stall_q <= '0;
         redir_q <= '0;
      end else begin
         if (op_bubble && stall_q != '1) stall_q <= stall_q + 32'd1;
         if (redir_evt && redir_q != '1) redir_q <= redir_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = redir_q;
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a queue-based reference model of the controller.
module tb_pipeline_controller;

   localparam int NT = 3;
`ifdef STALL_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        reset;
   logic        load_start, load_end;
   logic        id_valid, id_uses_rs, id_uses_rt, id_reg_write;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        wb_redirect, wb_uart_read, input_ready;
   logic        ex_uart_write, sender_full;
   logic        pc_enable, id_enable, op_bubble, pipe_enable;
   logic        flush, loading;
   logic [2:0]  state;
   logic [31:0] stall_cycles, flush_count;

   always #5 CLK = ~CLK;

   pipeline_controller #(.NUM_TRACK(NT), .REG_ADDR_WIDTH(5)) dut (
      .CLK(CLK), .reset(reset),
      .load_start(load_start), .load_end(load_end),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_reg_write(id_reg_write), .id_rd(id_rd),
      .wb_redirect(wb_redirect), .wb_uart_read(wb_uart_read),
      .input_ready(input_ready), .ex_uart_write(ex_uart_write),
      .sender_full(sender_full),
      .pc_enable(pc_enable), .id_enable(id_enable),
      .op_bubble(op_bubble), .pipe_enable(pipe_enable),
      .flush(flush), .loading(loading), .state(state),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // reference model: mode number, queue of in-flight destinations (0 = none)
   int          m_state;
   int          sb[$];
   logic [31:0] m_stall, m_redir;
   logic        e_pc, e_id, e_bub, e_pipe, e_fl, e_ld, e_redir;
   int          n_state;

   task automatic m_reset();
      m_state = 0;
      sb = {};
      repeat (NT) sb.push_back(0);
      m_stall = 0;
      m_redir = 0;
   endtask

   function automatic bit m_hazard();
      if (!id_valid) return 1'b0;
      foreach (sb[i]) begin
         if (sb[i] != 0 && id_uses_rs && sb[i] == int'(id_rs)) return 1'b1;
         if (sb[i] != 0 && id_uses_rt && sb[i] == int'(id_rt)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic m_freeze();
      e_pc = 0; e_id = 0; e_pipe = 0;
   endtask

   task automatic m_eval();
      bit run;
      e_pc = 1; e_id = 1; e_pipe = 1; e_bub = 0; e_fl = 0; e_ld = 0;
      e_redir = 0;
      n_state = m_state;
      run = 0;
      case (m_state)
         0: run = 1;
         1: begin
            e_ld = 1; e_fl = 1; m_freeze();
            if (load_end) n_state = 2;
         end
         2: begin e_fl = 1; e_id = 0; n_state = 0; end
         3: if (input_ready) run = 1; else m_freeze();
         4: if (!sender_full) run = 1; else m_freeze();
         default: n_state = 0;
      endcase
      if (run) begin
         n_state = 0;
         if (m_state == 0 && load_start) begin
            n_state = 1; e_fl = 1; m_freeze();
         end else if (wb_redirect) begin
            n_state = 2; e_fl = 1; e_redir = 1;
         end else if (wb_uart_read && !input_ready) begin
            n_state = 3; m_freeze();
         end else if (ex_uart_write && sender_full) begin
            n_state = 4; m_freeze();
         end else if (m_hazard()) begin
            e_pc = 0; e_id = 0; e_bub = 1;
         end
      end
   endtask

   task automatic m_commit();
      if (reset) begin
         m_reset();
         return;
      end
      if (e_fl) begin
         foreach (sb[i]) sb[i] = 0;
      end else if (e_pipe) begin
         sb.push_front((id_valid && e_id && id_reg_write) ? int'(id_rd) : 0);
         void'(sb.pop_back());
      end
      if (CNT_EN && e_bub && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (CNT_EN && e_redir && m_redir != 32'hFFFF_FFFF) m_redir++;
      m_state = n_state;
   endtask

   task automatic cycle();
      #2;
      m_eval();
      chk("ctrl", {23'd0, pc_enable, id_enable, op_bubble, pipe_enable,
                   flush, loading, state},
          {23'd0, e_pc, e_id, e_bub, e_pipe, e_fl, e_ld, 3'(m_state)});
      chk("stall_cycles", stall_cycles, m_stall);
      chk("flush_count", flush_count, m_redir);
      @(posedge CLK);
      m_commit();
      #1;
      cyc++;
   endtask

   task automatic idle();
      load_start = 0; load_end = 0; id_valid = 0; id_uses_rs = 0;
      id_uses_rt = 0; id_reg_write = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      wb_redirect = 0; wb_uart_read = 0; input_ready = 0;
      ex_uart_write = 0; sender_full = 0;
   endtask

   task automatic dec(input logic [4:0] rd, input logic wr,
                      input logic [4:0] rs, input logic urs);
      id_valid = 1; id_rd = rd; id_reg_write = wr;
      id_rs = rs; id_uses_rs = urs; id_rt = 0; id_uses_rt = 0;
   endtask

   int n_a, n_b;

   initial begin
      reset = 1;
      idle();
      repeat (2) @(posedge CLK);
      #1;
      m_reset();
      reset = 0;

      // back-to-back dependent pair
      dec(5'd3, 1, 5'd0, 0);
      cycle();
      dec(5'd0, 0, 5'd3, 1);
      n_a = 0; n_b = 0;
      repeat (4) begin
         #2;
         n_a += int'(op_bubble);
         n_b += int'(!pc_enable);
         cycle();
      end
      chk("b2b_bubbles", n_a, 3);
      chk("b2b_pc_hold", n_b, 3);
      chk("b2b_stall_cnt", stall_cycles, CNT_EN ? 32'd3 : 32'd0);

      // r0 writer then r0 reader
      dec(5'd0, 1, 5'd0, 0);
      cycle();
      dec(5'd0, 0, 5'd0, 1);
      n_a = 0;
      repeat (3) begin #2; n_a += int'(op_bubble); cycle(); end
      chk("r0_bubbles", n_a, 0);

      // redirect kills pending hazard
      dec(5'd5, 1, 5'd0, 0);
      cycle();
      dec(5'd0, 0, 5'd5, 1);
      wb_redirect = 1;
      n_a = 0; n_b = 0;
      #2; n_a += int'(flush); n_b += int'(op_bubble);
      cycle();
      wb_redirect = 0;
      repeat (2) begin
         #2; n_a += int'(flush); n_b += int'(op_bubble);
         cycle();
      end
      chk("redir_flush", n_a, 2);
      chk("redir_bubbles", n_b, 0);
      chk("redir_cnt", flush_count, CNT_EN ? 32'd1 : 32'd0);

      // UART input wait
      idle();
      wb_uart_read = 1;
      n_a = 0;
      repeat (5) begin #2; n_a += int'(!pipe_enable); cycle(); end
      chk("win_frozen", n_a, 5);
      chk("win_state", state, 32'd3);
      input_ready = 1;
      #2;
      chk("win_release", pipe_enable, 1);
      cycle();
      chk("win_exit", state, 32'd0);

      // program load
      idle();
      load_start = 1;
      cycle();
      load_start = 0;
      n_a = 0;
      repeat (3) begin #2; n_a += int'(loading && !pipe_enable); cycle(); end
      load_end = 1;
      #2; n_a += int'(loading && !pipe_enable);
      cycle();
      load_end = 0;
      chk("load_cycles", n_a, 4);
      chk("load_flush_state", state, 32'd2);
      cycle();
      chk("load_run", state, 32'd0);

      // reset during WAIT_OUT
      ex_uart_write = 1;
      sender_full = 1;
      repeat (2) cycle();
      reset = 1;
      cycle();
      reset = 0;
      chk("rst_state", state, 32'd0);
      chk("rst_stall", stall_cycles, 32'd0);
      cycle();

      // randomized traffic
      repeat (3000) begin
         reset         = ($urandom_range(0, 499) == 0);
         load_start    = ($urandom_range(0, 39) == 0);
         load_end      = ($urandom_range(0, 3) == 0);
         wb_redirect   = ($urandom_range(0, 15) == 0);
         wb_uart_read  = ($urandom_range(0, 9) == 0);
         input_ready   = 1'($urandom_range(0, 1));
         ex_uart_write = ($urandom_range(0, 9) == 0);
         sender_full   = 1'($urandom_range(0, 1));
         id_valid      = ($urandom_range(0, 3) != 0);
         id_reg_write  = 1'($urandom_range(0, 1));
         id_uses_rs    = 1'($urandom_range(0, 1));
         id_uses_rt    = 1'($urandom_range(0, 1));
         id_rd         = 5'($urandom_range(0, 3));
         id_rs         = 5'($urandom_range(0, 3));
         id_rt         = 5'($urandom_range(0, 3));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central sequencing block for the six-stage CPU pipeline (fetch, decode, operand fetch, execution, memory access, write-back). It owns every stage-register enable, bubble and flush control. It tracks in-flight register destinations to stall decode on RAW hazards, and kills wrong-path instructions after a write-back redirect. It freezes the pipeline while UART input or output is not ready, and holds it during program loading.

## Interface
Parameters:
- NUM_TRACK, 3: in-flight destination slots between decode and write-back (EX, MEM, WB-input). The WB-stage write is bypassed by operand fetch and is not tracked.
- REG_ADDR_WIDTH, 5: register index width.

Ports:
- CLK  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  program-load request (push switch).
- load_end  in  1  program-load done (push switch).
- id_valid  in  1  decode holds a real instruction, not a bubble.
- id_rs, id_rt  in  5  decode source indices.
- id_uses_rs, id_uses_rt  in  1  source actually read.
- id_reg_write  in  1  decode instruction writes a register.
- id_rd  in  5  final destination index, after RegDist selection.
- wb_redirect  in  1  write-back generated a non-sequential PC (taken branch/jump).
- wb_uart_read  in  1  write-back instruction is UARTtoReg.
- input_ready  in  1  receiver buffer holds a full word.
- ex_uart_write  in  1  execution instruction is RegtoUART.
- sender_full  in  1  sender buffer cannot accept a byte.
- pc_enable  out  1  fetch may advance the PC.
- id_enable  out  1  fetch->decode register may load.
- op_bubble  out  1  load an invalid (distinct=1) instruction into operand->execution.
- pipe_enable  out  1  operand/execution/memory/write-back stage registers advance.
- flush  out  1  invalidate decode and all stages younger than write-back.
- loading  out  1  load phase active.
- state  out  3  current FSM state.
- stall_cycles  out  32  hazard-stall cycle count.
- flush_count  out  32  redirect count.

## Operation
- FSM states: RUN=0, LOAD=1, FLUSH=2, WAIT_IN=3, WAIT_OUT=4. Reset state is RUN.
- Reset values: pc_enable=1, id_enable=1, pipe_enable=1, op_bubble=0, flush=0, loading=0, state=RUN, all slots invalid, counters 0.
- Scoreboard slot k holds {valid, rd}. On a pipe_enable cycle, slot0 gets {1, id_rd} only if id_valid, id_enable, id_reg_write and id_rd!=0; otherwise slot0 is invalid. Slot k gets slot k-1. On flush, all slots are invalid. When pipe_enable=0, slots hold.
- hazard = id_valid and ((id_uses_rs and rs matches any valid slot) or (id_uses_rt and rt matches any valid slot)). Register 0 never matches.
- RUN priority, highest first:
  - load_start: go to LOAD; flush=1.
  - wb_redirect: flush=1 in this cycle; go to FLUSH.
  - wb_uart_read and !input_ready: go to WAIT_IN; all enables 0.
  - ex_uart_write and sender_full: go to WAIT_OUT; all enables 0.
  - hazard: pc_enable=0, id_enable=0, op_bubble=1, pipe_enable=1.
  - Otherwise: all enables 1.
- LOAD: loading=1, pipe_enable=0, flush=1, pc_enable=0. On load_end go to FLUSH.
- FLUSH: exactly one cycle; flush=1, pc_enable=1, id_enable=0, so the stale fetch is discarded; then RUN.
- WAIT_IN / WAIT_OUT: all enables 0 while waiting. When the condition clears (input_ready=1 / sender_full=0), outputs follow RUN rules in that same cycle and state returns to RUN.
- reset overrides every state, including mid-LOAD and mid-wait.

## Timing
- All outputs are combinational from the registered state, scoreboard and current inputs; no added latency. A hazard stalls decode in the same cycle it appears.
- A back-to-back dependent pair gives NUM_TRACK bubble cycles. A dependence at distance d gives max(0, NUM_TRACK-d+1) bubbles.
- Redirect penalty: the redirect cycle plus one FLUSH cycle.
- load_start is ignored outside RUN. load_end is ignored outside LOAD.

## Configuration
- STALL_COUNTERS_EN defined: stall_cycles increments on each RUN cycle with hazard; flush_count increments on each wb_redirect. Both saturate at 2^32-1 and clear on reset.
- STALL_COUNTERS_EN undefined: both ports are tied to 0 and no counter logic exists.

## Structure
- Shared package cpu_ctrl_pkg holds: ctrl_state_t enum (3-bit, values above), sb_slot_t struct {valid, rd}, and the REG_ADDR_WIDTH constant.
- One sub-module, hazard_scoreboard, contains the slot shift register and the match logic. The FSM and enables stay in pipeline_controller.

## Test plan
- Decode add r3 with id_valid, then next decode reads rs=3 -> op_bubble=1 and pc_enable=0 for 3 cycles; 4th cycle all enables 1; stall_cycles=3.
- Decode rd=0 writer followed by a reader of r0 -> no stall.
- wb_redirect=1 for one cycle -> flush=1 for 2 cycles (RUN then FLUSH), all slots invalid, pending-hazard decode no longer stalls; flush_count=1.
- wb_uart_read=1 with input_ready=0 for 5 cycles -> state=WAIT_IN, pipe_enable=0 for 5 cycles; input_ready rises -> pipe_enable=1 that cycle, state=RUN.
- load_start pulse -> loading=1, pipe_enable=0 until load_end; then one FLUSH cycle, then RUN.
- Assert reset during WAIT_OUT with sender_full=1 -> next cycle state=RUN, all reset values restored.
